// File: rtl/bp_fe_pkg.sv
// Front-end shared types and configuration for the fetch assembler and its helpers.
// Processor configurations are resolved to plain integer parameters by bp_get_proc_params.
package bp_fe_pkg;

    typedef enum logic {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    typedef struct packed {
        int vaddr_width;
        int fetch_cinstr;
        int fetch_ptr;
        int fetch_sel;
        int branch_metadata_fwd_width;
    } bp_proc_param_s;

    localparam int cinstr_width_gp                = 16;
    localparam int default_vaddr_width_gp         = 39;
    localparam int default_fetch_cinstr_gp        = 4;
    localparam int default_fetch_ptr_gp           = 3;
    localparam int default_fetch_sel_gp           = 2;
    localparam int default_br_metadata_fwd_width_gp = 8;
    localparam int bp_fe_asm_buf_parcels_gp       = 2 * default_fetch_cinstr_gp;

    // bound = parcels still buffered that belong to this fetch
    typedef struct packed {
        logic                                        v;
        logic [default_fetch_ptr_gp-1:0]             bound;
        logic [default_br_metadata_fwd_width_gp-1:0] br_metadata_fwd;
    } bp_fe_assembler_meta_s;

    function automatic bp_proc_param_s bp_get_proc_params(bp_params_e cfg);
        bp_proc_param_s p;
        case (cfg)
            e_bp_default_cfg: p = '{default_vaddr_width_gp, default_fetch_cinstr_gp,
                                    default_fetch_ptr_gp, default_fetch_sel_gp,
                                    default_br_metadata_fwd_width_gp};
            default:          p = '{default_vaddr_width_gp, default_fetch_cinstr_gp,
                                    default_fetch_ptr_gp, default_fetch_sel_gp,
                                    default_br_metadata_fwd_width_gp};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/bp_fe_parcel_align.sv
// Right-shifts a block of 16-bit parcels by shift_i parcels, zero-filling at the top.
// Used both to drop leading parcels of a fetch and to retire consumed parcels.
module bp_fe_parcel_align
    import bp_fe_pkg::*;
#(
    parameter int parcels_p     = 4,
    parameter int shift_width_p = 2
)(
    input  logic [parcels_p*cinstr_width_gp-1:0] data_i,
    input  logic [shift_width_p-1:0]             shift_i,
    output logic [parcels_p*cinstr_width_gp-1:0] data_o
);

    localparam int lg_parcel_lp = $clog2(cinstr_width_gp);

    assign data_o = data_i >> {shift_i, {lg_parcel_lp{1'b0}}};

endmodule

// File: rtl/bp_fe_fetch_assembler.sv
// Fetch assembler: buffers block-aligned I$ returns as parcels and presents a scan window.
// Optional BP_FE_ASSEMBLER_BYPASS_EN drives the window straight from a fetch into an empty buffer.
module bp_fe_fetch_assembler
    import bp_fe_pkg::*;
#(
    parameter  bp_params_e     bp_params_p                 = e_bp_default_cfg,
    localparam bp_proc_param_s proc_param_lp               = bp_get_proc_params(bp_params_p),
    localparam int             vaddr_width_p               = proc_param_lp.vaddr_width,
    localparam int             fetch_cinstr_p              = proc_param_lp.fetch_cinstr,
    localparam int             fetch_ptr_p                 = proc_param_lp.fetch_ptr,
    localparam int             fetch_sel_p                 = proc_param_lp.fetch_sel,
    localparam int             branch_metadata_fwd_width_p = proc_param_lp.branch_metadata_fwd_width,
    localparam int             buf_parcels_lp              = 2 * fetch_cinstr_p
)(
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   redirect_i,
    input  logic                                   fetch_v_i,
    input  logic [vaddr_width_p-1:0]               fetch_pc_i,
    input  logic [fetch_cinstr_p*16-1:0]           fetch_data_i,
    input  logic [branch_metadata_fwd_width_p-1:0] fetch_br_metadata_fwd_i,
    output logic                                   fetch_ready_o,
    output logic                                   assembled_v_o,
    output logic [vaddr_width_p-1:0]               assembled_pc_o,
    output logic [fetch_cinstr_p*16-1:0]           assembled_instr_o,
    output logic [branch_metadata_fwd_width_p-1:0] assembled_br_metadata_fwd_o,
    output logic [fetch_ptr_p-1:0]                 assembled_count_o,
    output logic                                   assembled_partial_o,
    input  logic [fetch_ptr_p-1:0]                 assembled_count_i,
    input  logic                                   assembled_yumi_i
);

    localparam int block_width_lp = fetch_cinstr_p * cinstr_width_gp;
    localparam int buf_width_lp   = buf_parcels_lp * cinstr_width_gp;
    localparam int count_width_lp = $clog2(buf_parcels_lp + 1);
    localparam int lg_parcel_lp   = $clog2(cinstr_width_gp);

    // Handshakes: a fetch transfers when fetch_v_i & fetch_ready_o at a clock edge, and
    // ready never depends on fetch_v_i; the scan side retires assembled_count_i parcels on
    // assembled_yumi_i, which it may only raise while assembled_v_o is high.

    logic [buf_width_lp-1:0]   buf_q, buf_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic [vaddr_width_p-1:0]  head_pc_q, head_pc_d;
    bp_fe_assembler_meta_s     meta0_q, meta0_d, meta1_q, meta1_d;

    logic [fetch_sel_p-1:0]    off;
    logic [fetch_ptr_p-1:0]    n_in;
    logic [block_width_lp-1:0] fetch_aligned;
    logic                      enq, bypass, enq_buf;
    bp_fe_assembler_meta_s     new_meta;

    logic [buf_width_lp-1:0]   src_buf, head_shifted, enq_placed;
    logic [count_width_lp-1:0] src_count, surv;
    logic [vaddr_width_p-1:0]  src_pc;
    bp_fe_assembler_meta_s     src_meta0;
    logic [fetch_ptr_p-1:0]    cons_ptr;
    logic                      pop;

    assign off      = fetch_pc_i[fetch_sel_p:1];
    assign n_in     = fetch_ptr_p'(fetch_cinstr_p) - fetch_ptr_p'(off);
    assign new_meta = '{v: 1'b1, bound: n_in, br_metadata_fwd: fetch_br_metadata_fwd_i};

    // Two meta entries also bound the number of fetches that can be in flight
    assign fetch_ready_o = (count_q <= count_width_lp'(buf_parcels_lp - fetch_cinstr_p))
                         & ~meta1_q.v;
    assign enq           = fetch_v_i & fetch_ready_o;

`ifdef BP_FE_ASSEMBLER_BYPASS_EN
    assign bypass = (count_q == '0) & enq & ~redirect_i;
`else
    assign bypass = 1'b0;
`endif
    assign enq_buf = enq & ~bypass;

    bp_fe_parcel_align #(
        .parcels_p    (fetch_cinstr_p),
        .shift_width_p(fetch_sel_p)
    ) u_enq_align (
        .data_i (fetch_data_i),
        .shift_i(off),
        .data_o (fetch_aligned)
    );

    // A bypassed fetch is treated as if it were already the buffer contents
    assign src_buf   = bypass ? buf_width_lp'(fetch_aligned) : buf_q;
    assign src_count = bypass ? count_width_lp'(n_in) : count_q;
    assign src_pc    = bypass ? fetch_pc_i : head_pc_q;
    assign src_meta0 = bypass ? new_meta : meta0_q;

    assign cons_ptr = assembled_yumi_i ? assembled_count_i : '0;

    bp_fe_parcel_align #(
        .parcels_p    (buf_parcels_lp),
        .shift_width_p(fetch_ptr_p)
    ) u_head_align (
        .data_i (src_buf),
        .shift_i(cons_ptr),
        .data_o (head_shifted)
    );

    assign surv       = src_count - count_width_lp'(cons_ptr);
    assign enq_placed = buf_width_lp'(fetch_aligned) << {surv, {lg_parcel_lp{1'b0}}};
    assign pop        = src_meta0.v & (cons_ptr >= src_meta0.bound);

    always_comb begin
        buf_d         = head_shifted | (enq_buf ? enq_placed : '0);
        count_d       = surv + (enq_buf ? count_width_lp'(n_in) : '0);
        head_pc_d     = src_pc + vaddr_width_p'({cons_ptr, 1'b0});
        meta0_d       = src_meta0;
        meta0_d.bound = src_meta0.bound - cons_ptr;
        meta1_d       = meta1_q;
        if (pop) begin
            meta0_d       = meta1_q;
            meta0_d.bound = meta1_q.bound - (cons_ptr - src_meta0.bound);
            meta1_d       = '0;
        end
        if (surv == '0) begin
            meta0_d = '0;
            meta1_d = '0;
        end
        if (enq_buf) begin
            if (surv == '0) begin
                meta0_d   = new_meta;
                head_pc_d = fetch_pc_i;
            end else begin
                meta1_d = new_meta;
            end
        end
        if (redirect_i) begin
            buf_d     = '0;
            count_d   = '0;
            meta0_d   = '0;
            meta1_d   = '0;
            head_pc_d = head_pc_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            buf_q     <= '0;
            count_q   <= '0;
            head_pc_q <= '0;
            meta0_q   <= '0;
            meta1_q   <= '0;
        end else begin
            buf_q     <= buf_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
            meta0_q   <= meta0_d;
            meta1_q   <= meta1_d;
        end
    end

    assign assembled_v_o               = (src_count != '0);
    assign assembled_pc_o              = src_pc;
    assign assembled_instr_o           = src_buf[block_width_lp-1:0];
    assign assembled_br_metadata_fwd_o = src_meta0.br_metadata_fwd;
    assign assembled_count_o           = (src_count >= count_width_lp'(fetch_cinstr_p))
                                       ? fetch_ptr_p'(fetch_cinstr_p)
                                       : fetch_ptr_p'(src_count);
    assign assembled_partial_o         = assembled_v_o
                                       & (src_count < count_width_lp'(fetch_cinstr_p));

    a_consume_within_window: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        assembled_yumi_i |-> (assembled_count_i <= assembled_count_o)
    );

endmodule

// File: tb/tb_bp_fe_fetch_assembler.sv
// Directed bench for bp_fe_fetch_assembler with hand-computed window expectations.
module tb_bp_fe_fetch_assembler;
    import bp_fe_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic        fetch_v_i = 1'b0;
    logic [38:0] fetch_pc_i = '0;
    logic [63:0] fetch_data_i = '0;
    logic [7:0]  fetch_br_metadata_fwd_i = '0;
    logic        fetch_ready_o;
    logic        assembled_v_o;
    logic [38:0] assembled_pc_o;
    logic [63:0] assembled_instr_o;
    logic [7:0]  assembled_br_metadata_fwd_o;
    logic [2:0]  assembled_count_o;
    logic        assembled_partial_o;
    logic [2:0]  assembled_count_i = '0;
    logic        assembled_yumi_i = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [63:0] exp_q[$];

    bp_fe_fetch_assembler dut (
        .clk_i                      (clk_i),
        .reset_n_i                  (reset_n_i),
        .redirect_i                 (redirect_i),
        .fetch_v_i                  (fetch_v_i),
        .fetch_pc_i                 (fetch_pc_i),
        .fetch_data_i               (fetch_data_i),
        .fetch_br_metadata_fwd_i    (fetch_br_metadata_fwd_i),
        .fetch_ready_o              (fetch_ready_o),
        .assembled_v_o              (assembled_v_o),
        .assembled_pc_o             (assembled_pc_o),
        .assembled_instr_o          (assembled_instr_o),
        .assembled_br_metadata_fwd_o(assembled_br_metadata_fwd_o),
        .assembled_count_o          (assembled_count_o),
        .assembled_partial_o        (assembled_partial_o),
        .assembled_count_i          (assembled_count_i),
        .assembled_yumi_i           (assembled_yumi_i)
    );

    // clock
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        fetch_v_i         = 1'b0;
        assembled_yumi_i  = 1'b0;
        assembled_count_i = '0;
        redirect_i        = 1'b0;
    endtask

    task automatic drive_fetch(input logic [38:0] pc, input logic [63:0] data, input logic [7:0] md);
        fetch_v_i               = 1'b1;
        fetch_pc_i              = pc;
        fetch_data_i            = data;
        fetch_br_metadata_fwd_i = md;
    endtask

    task automatic drive_yumi(input logic [2:0] n);
        assembled_yumi_i  = 1'b1;
        assembled_count_i = n;
    endtask

    task automatic check_window(input string tag, input logic [38:0] pc, input logic [2:0] cnt,
                                input logic [63:0] instr, input logic partial, input logic [7:0] md);
        check_eq({tag, ".v"}, 64'(assembled_v_o), 64'h1);
        check_eq({tag, ".pc"}, 64'(assembled_pc_o), 64'(pc));
        check_eq({tag, ".count"}, 64'(assembled_count_o), 64'(cnt));
        check_eq({tag, ".instr"}, assembled_instr_o, instr);
        check_eq({tag, ".partial"}, 64'(assembled_partial_o), 64'(partial));
        check_eq({tag, ".md"}, 64'(assembled_br_metadata_fwd_o), 64'(md));
    endtask

    task automatic check_empty(input string tag);
        check_eq({tag, ".v"}, 64'(assembled_v_o), 64'h0);
        check_eq({tag, ".count"}, 64'(assembled_count_o), 64'h0);
        check_eq({tag, ".instr"}, assembled_instr_o, 64'h0);
        check_eq({tag, ".partial"}, 64'(assembled_partial_o), 64'h0);
        check_eq({tag, ".ready"}, 64'(fetch_ready_o), 64'h1);
    endtask

    initial begin
        // reset
        #1;
        check_eq("rst.pc", 64'(assembled_pc_o), 64'h0);
        check_eq("rst.md", 64'(assembled_br_metadata_fwd_o), 64'h0);
        check_empty("rst");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;

        // misaligned fetch, then enqueue behind a survivor, then pop with overflow
        drive_fetch(39'h1004, 64'hDDDD_CCCC_BBBB_AAAA, 8'h33);
        step();
        check_window("mis", 39'h1004, 3'd2, 64'h0000_0000_DDDD_CCCC, 1'b1, 8'h33);
        drive_fetch(39'h1008, 64'hF3F3_F2F2_F1F1_F0F0, 8'h44);
        drive_yumi(3'd1);
        step();
        check_window("mis_enq", 39'h1006, 3'd4, 64'hF2F2_F1F1_F0F0_DDDD, 1'b0, 8'h33);
        drive_yumi(3'd2);
        step();
        check_window("mis_pop", 39'h100a, 3'd3, 64'h0000_F3F3_F2F2_F1F1, 1'b1, 8'h44);
        drive_yumi(3'd3);
        step();
        check_empty("mis_drain");
        check_eq("mis_drain.pc", 64'(assembled_pc_o), 64'h1010);

        // straddling instruction across two fetch blocks
        exp_q.push_back(64'hA003_A002_A001_A000);
        exp_q.push_back(64'hA003_A002_A001_A000);
        exp_q.push_back(64'hB002_B001_B000_A003);
        exp_q.push_back(64'h0000_0000_0000_B003);
        drive_fetch(39'h2000, 64'hA003_A002_A001_A000, 8'h11);
        step();
        check_window("str0", 39'h2000, 3'd4, exp_q.pop_front(), 1'b0, 8'h11);
        check_eq("str0.ready", 64'(fetch_ready_o), 64'h1);
        drive_fetch(39'h2008, 64'hB003_B002_B001_B000, 8'h22);
        step();
        check_window("str1", 39'h2000, 3'd4, exp_q.pop_front(), 1'b0, 8'h11);
        check_eq("str1.ready", 64'(fetch_ready_o), 64'h0);
        drive_yumi(3'd3);
        step();
        check_window("str2", 39'h2006, 3'd4, exp_q.pop_front(), 1'b0, 8'h11);
        drive_yumi(3'd4);
        step();
        check_window("str3", 39'h200e, 3'd1, exp_q.pop_front(), 1'b1, 8'h22);
        drive_yumi(3'd1);
        step();
        check_empty("str_drain");

        // backpressure with a held third fetch
        drive_fetch(39'h6000, 64'h1003_1002_1001_1000, 8'hA1);
        step();
        check_eq("bp0.ready", 64'(fetch_ready_o), 64'h1);
        drive_fetch(39'h6008, 64'h2003_2002_2001_2000, 8'hA2);
        step();
        check_eq("bp1.ready", 64'(fetch_ready_o), 64'h0);
        drive_fetch(39'h6010, 64'h3003_3002_3001_3000, 8'hA3);
        step();
        check_window("bp_hold", 39'h6000, 3'd4, 64'h1003_1002_1001_1000, 1'b0, 8'hA1);
        check_eq("bp_hold.ready", 64'(fetch_ready_o), 64'h0);
        drive_fetch(39'h6010, 64'h3003_3002_3001_3000, 8'hA3);
        drive_yumi(3'd4);
        step();
        check_window("bp_cons", 39'h6008, 3'd4, 64'h2003_2002_2001_2000, 1'b0, 8'hA2);
        check_eq("bp_cons.ready", 64'(fetch_ready_o), 64'h1);
        drive_fetch(39'h6010, 64'h3003_3002_3001_3000, 8'hA3);
        step();
        check_eq("bp_acc.ready", 64'(fetch_ready_o), 64'h0);
        drive_yumi(3'd4);
        step();
        check_window("bp_f3", 39'h6010, 3'd4, 64'h3003_3002_3001_3000, 1'b0, 8'hA3);
        drive_yumi(3'd4);
        step();
        check_empty("bp_drain");

        // redirect beats a concurrent fetch and yumi
        drive_fetch(39'h7000, 64'h7003_7002_7001_7000, 8'h70);
        step();
        drive_fetch(39'h7008, 64'h7007_7006_7005_7004, 8'h71);
        drive_yumi(3'd2);
        redirect_i = 1'b1;
        step();
        check_empty("redir");
        drive_fetch(39'h3002, 64'hDDDD_CCCC_BBBB_AAAA, 8'h55);
        step();
        check_window("redir_f", 39'h3002, 3'd3, 64'h0000_DDDD_CCCC_BBBB, 1'b1, 8'h55);
        drive_yumi(3'd3);
        step();
        check_empty("redir_drain");

        // asynchronous reset with six parcels buffered
        drive_fetch(39'h4000, 64'h4003_4002_4001_4000, 8'h40);
        step();
        drive_fetch(39'h4004, 64'h4007_4006_4005_4004, 8'h41);
        step();
        check_eq("arst_pre.count", 64'(assembled_count_o), 64'h4);
        #2;
        reset_n_i = 1'b0;
        #1;
        check_eq("arst.pc", 64'(assembled_pc_o), 64'h0);
        check_eq("arst.md", 64'(assembled_br_metadata_fwd_o), 64'h0);
        check_empty("arst");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step();
        check_empty("arst_rel");
        drive_fetch(39'h5000, 64'h5003_5002_5001_5000, 8'h66);
        step();
        check_window("arst_f", 39'h5000, 3'd4, 64'h5003_5002_5001_5000, 1'b0, 8'h66);
        drive_yumi(3'd4);
        step();
        check_empty("arst_drain");

        // fetch into an empty buffer: same-cycle window only with bypass
        drive_fetch(39'h8002, 64'h8003_8002_8001_8000, 8'h77);
        #1;
`ifdef BP_FE_ASSEMBLER_BYPASS_EN
        check_eq("byp_same.v", 64'(assembled_v_o), 64'h1);
        check_eq("byp_same.count", 64'(assembled_count_o), 64'h3);
`else
        check_eq("byp_same.v", 64'(assembled_v_o), 64'h0);
        check_eq("byp_same.count", 64'(assembled_count_o), 64'h0);
`endif
        step();
        check_window("byp_next", 39'h8002, 3'd3, 64'h0000_8003_8002_8001, 1'b1, 8'h77);
        drive_yumi(3'd3);
        step();
        check_empty("byp_drain");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
